rv32i_int_ctrl: RTL and testbench

- Interrupt controller between the SoPC external interrupt lines (int_i[15:0]) and the RV32I core.
- Captures edge- or level-type requests per source, masks them, and arbitrates among pending sources.
- Presents a single request plus source ID to the core, then runs a claim/complete handshake so only one interrupt is in service at a time.
- Configured by the core through a small register port.

---
 rtl/rv32i_int_ctrl_pkg.sv | 20 ++
 rtl/rv32i_int_ctrl_arb.sv | 45 ++++
 rtl/rv32i_int_ctrl.sv | 152 +++++++++++++++
 tb/tb_rv32i_int_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_int_ctrl_pkg.sv
// Shared definitions for the rv32i interrupt controller.
// Contents: register address map, FSM state encoding, reset level constants.
// Optional feature macro used elsewhere: RV32I_INTC_RR_EN (round-robin arbitration).
package rv32i_int_ctrl_pkg;

  localparam logic [1:0] INTC_ENABLE   = 2'd0;
  localparam logic [1:0] INTC_EDGE_SEL = 2'd1;
  localparam logic [1:0] INTC_PENDING  = 2'd2;
  localparam logic [1:0] INTC_STATUS   = 2'd3;

  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/rv32i_int_ctrl_arb.sv
// Combinational arbiter picking one source out of the eligible vector.
// Default build: fixed priority, lowest index wins.
// With RV32I_INTC_RR_EN defined: first eligible index at or above ptr, wrapping.
// Ports:
//   eligible  in   NUM_SRC  pending & enabled sources
//   ptr       in   ID_W     round-robin start index (RV32I_INTC_RR_EN only)
//   winner    out  ID_W     selected source
//   valid     out  1        any source eligible
module rv32i_int_arb
  import rv32i_int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int ID_W    = 4
) (
  input  logic [NUM_SRC-1:0] eligible,
`ifdef RV32I_INTC_RR_EN
  input  logic [ID_W-1:0]    ptr,
`endif
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  // Scanning from the far end down means the last hit assigned is the
  // highest-priority one, so no early exit is needed.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
`ifdef RV32I_INTC_RR_EN
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (eligible[(int'(ptr) + k) % NUM_SRC]) begin
        winner = ID_W'((int'(ptr) + k) % NUM_SRC);
        valid  = 1'b1;
      end
    end
`else
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = ID_W'(i);
        valid  = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/rv32i_int_ctrl.sv
// Interrupt controller between the external interrupt lines and the RV32I core.
// Captures edge/level requests, masks them, arbitrates, and runs a
// claim/complete handshake so only one interrupt is in service at a time.
// Optional macro: RV32I_INTC_RR_EN selects round-robin arbitration.
// Ports:
//   clk, rst (async, active-low)
//   int_i        raw interrupt lines, already synchronous to clk
//   cfg_we_i / cfg_addr_i / cfg_wdata_i / cfg_rdata_o   register port
//   irq_o, irq_id_o       request and source ID to the core
//   irq_ack_i, irq_eoi_i  claim and end-of-interrupt pulses
//   busy_o                high while an interrupt is in service
//
// state   | meaning
// IDLE    | nothing requested, waiting for an eligible source
// REQ     | irq_o high, ID tracks the current winner until claimed
// SERVICE | source claimed, waiting for end-of-interrupt
module rv32i_int_ctrl
  import rv32i_int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] int_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o,
  input  logic               irq_ack_i,
  input  logic               irq_eoi_i,
  output logic               busy_o
);

  state_t state, next_state;

  logic [NUM_SRC-1:0] enable, edge_sel, pending, int_q;
  logic [NUM_SRC-1:0] eligible, w1c, claim_clr;
  logic [ID_W-1:0]    id_q, claimed_id, winner;
  logic               win_valid, claim;
  logic               unused_wdata;

  assign unused_wdata = &{1'b0, cfg_wdata_i};

  assign eligible  = pending & enable;
  // A claim needs something still eligible; otherwise REQ falls back to IDLE.
  assign claim     = (state == REQ) && win_valid && irq_ack_i;
  assign w1c       = (cfg_we_i && cfg_addr_i == INTC_PENDING) ? cfg_wdata_i[NUM_SRC-1:0] : '0;
  assign claim_clr = claim ? (NUM_SRC'(1) << id_q) : '0;

`ifdef RV32I_INTC_RR_EN
  logic [ID_W-1:0] ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable)
      ptr <= '0;
    else if (claim)
      ptr <= (id_q == ID_W'(NUM_SRC - 1)) ? '0 : id_q + ID_W'(1);
  end
`endif

  rv32i_int_arb #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_arb (
    .eligible (eligible),
`ifdef RV32I_INTC_RR_EN
    .ptr      (ptr),
`endif
    .winner   (winner),
    .valid    (win_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      enable   <= '0;
      edge_sel <= '0;
    end else if (cfg_we_i) begin
      if (cfg_addr_i == INTC_ENABLE)   enable   <= cfg_wdata_i[NUM_SRC-1:0];
      if (cfg_addr_i == INTC_EDGE_SEL) edge_sel <= cfg_wdata_i[NUM_SRC-1:0];
    end
  end

  // Edge sources: set on a rising edge, which overrides any clear in the
  // same cycle. Level sources simply follow the line.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      int_q   <= '0;
      pending <= '0;
    end else begin
      int_q   <= int_i;
      pending <= (edge_sel & ((pending & ~(w1c | claim_clr)) | (int_i & ~int_q)))
               | (~edge_sel & int_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_valid) next_state = REQ;
      REQ: begin
        if (!win_valid)     next_state = IDLE;
        else if (irq_ack_i) next_state = SERVICE;
      end
      SERVICE: if (irq_eoi_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // id_q follows the winner while requesting and freezes once claimed, so it
  // doubles as the in-service ID.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      id_q       <= '0;
      claimed_id <= '0;
    end else begin
      if (win_valid && (state == IDLE || (state == REQ && !irq_ack_i)))
        id_q <= winner;
      if (claim)
        claimed_id <= id_q;
    end
  end

  always_comb begin
    irq_o    = (state == REQ);
    busy_o   = (state == SERVICE);
    irq_id_o = id_q;
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      INTC_ENABLE:   cfg_rdata_o[NUM_SRC-1:0] = enable;
      INTC_EDGE_SEL: cfg_rdata_o[NUM_SRC-1:0] = edge_sel;
      INTC_PENDING:  cfg_rdata_o[NUM_SRC-1:0] = pending;
      default: begin
        cfg_rdata_o[17:16]     = state;
        cfg_rdata_o[ID_W-1:0] = claimed_id;
      end
    endcase
  end

endmodule

// File: tb/tb_rv32i_int_ctrl.sv
// Directed self-checking bench for rv32i_int_ctrl.
module tb_rv32i_int_ctrl;
  import rv32i_int_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] int_i;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq;
  logic [3:0]  irq_id;
  logic        irq_ack;
  logic        irq_eoi;
  logic        busy;

  int vectors = 0;
  int errs    = 0;
  int exp_q[$];

  rv32i_int_ctrl #(.NUM_SRC(16), .ID_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .int_i       (int_i),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rdata_o (cfg_rdata),
    .irq_o       (irq),
    .irq_id_o    (irq_id),
    .irq_ack_i   (irq_ack),
    .irq_eoi_i   (irq_eoi),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  // Pops the next expected claim ID, claims it, checks SERVICE, then ends it.
  task automatic claim_and_finish(input string tag, input bit edge_src);
    int exp;
    logic [31:0] d;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'hFF;
    check({tag, "_irq"}, 32'(irq), 32'd1);
    check({tag, "_id"}, 32'(irq_id), 32'(exp));
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_irq_svc"}, 32'(irq), 32'd0);
    check({tag, "_id_svc"}, 32'(irq_id), 32'(exp));
    cfg_read(INTC_STATUS, d);
    check({tag, "_status"}, d, 32'h0002_0000 | 32'(exp));
    if (edge_src) begin
      cfg_read(INTC_PENDING, d);
      check({tag, "_pend_clr"}, (d >> exp) & 32'd1, 32'd0);
    end
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
    check({tag, "_busy_eoi"}, 32'(busy), 32'd0);
    check({tag, "_irq_eoi"}, 32'(irq), 32'd0);
  endtask

  task automatic service(input string tag, input bit edge_src);
    int n = 0;
    while (irq !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    claim_and_finish(tag, edge_src);
  endtask

  initial begin
    logic [31:0] d;
    rst = RstEnable; int_i = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    irq_ack = 1'b0; irq_eoi = 1'b0;
    step(2);
    rst = RstDisable;
    step();

    // Reset state
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    cfg_read(INTC_ENABLE, d);   check("rst_enable", d, 32'd0);
    cfg_read(INTC_EDGE_SEL, d); check("rst_edge", d, 32'd0);
    cfg_read(INTC_PENDING, d);  check("rst_pend", d, 32'd0);
    cfg_read(INTC_STATUS, d);   check("rst_status", d, 32'd0);

    // Edge capture with exact latency
    cfg_write(INTC_EDGE_SEL, 32'hFFFF);
    cfg_write(INTC_ENABLE, 32'h0004);
    exp_q.push_back(2);
    int_i[2] = 1'b1; step(); int_i[2] = 1'b0;
    check("t1_irq_edge1", 32'(irq), 32'd0);
    cfg_read(INTC_PENDING, d); check("t1_pend_set", d, 32'h0004);
    step();
    claim_and_finish("t1", 1'b1);
    step(2);
    check("t1_irq_quiet", 32'(irq), 32'd0);

    // Pre-emption before the claim
    cfg_write(INTC_ENABLE, 32'hFFFF);
    exp_q.push_back(3);
    exp_q.push_back(9);
    int_i[9] = 1'b1; step();
    int_i[3] = 1'b1; step();
    check("t2_first_irq", 32'(irq), 32'd1);
    check("t2_first_id", 32'(irq_id), 32'd9);
    step();
    claim_and_finish("t2a", 1'b1);
    service("t2b", 1'b1);
    int_i = '0;
    step();

    // W1C on an edge source, and ignored STATUS write
    cfg_write(INTC_ENABLE, 32'h0);
    int_i[6] = 1'b1; step(); int_i[6] = 1'b0; step();
    cfg_read(INTC_PENDING, d); check("t3_w1c_pre", d, 32'h0040);
    check("t3_masked_irq", 32'(irq), 32'd0);
    cfg_write(INTC_PENDING, 32'h0040);
    cfg_read(INTC_PENDING, d); check("t3_w1c_post", d, 32'h0);
    cfg_write(INTC_STATUS, 32'hFFFF_FFFF);
    cfg_read(INTC_STATUS, d); check("t3_status_ro", d, 32'h9);

    // Level masking
    cfg_write(INTC_EDGE_SEL, 32'h0);
    int_i[5] = 1'b1;
    step(3);
    check("t3_lvl_masked", 32'(irq), 32'd0);
    cfg_read(INTC_PENDING, d); check("t3_lvl_pend", d, 32'h0020);
    cfg_write(INTC_ENABLE, 32'h0020);
    check("t3_en_wr_edge", 32'(irq), 32'd0);
    step();
    check("t3_en_irq", 32'(irq), 32'd1);
    check("t3_en_id", 32'(irq_id), 32'd5);
    cfg_write(INTC_ENABLE, 32'h0);
    check("t3_mask_wr_edge", 32'(irq), 32'd1);
    step();
    check("t3_mask_idle", 32'(irq), 32'd0);
    int_i[5] = 1'b0;
    step();

    // Stray handshakes in IDLE, then level re-trigger
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
    cfg_read(INTC_STATUS, d); check("t4_stray_eoi", d, 32'h9);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("t4_stray_ack", 32'(busy), 32'd0);
    cfg_write(INTC_ENABLE, 32'h0001);
    int_i[0] = 1'b1;
    exp_q.push_back(0);
    service("t4a", 1'b0);
    step();
    check("t4_retrig_irq", 32'(irq), 32'd1);
    check("t4_retrig_id", 32'(irq_id), 32'd0);
    exp_q.push_back(0);
    claim_and_finish("t4b", 1'b0);
    int_i[0] = 1'b0;
    step(3);
    check("t4_drop_irq", 32'(irq), 32'd0);

    // Reset in SERVICE
    cfg_write(INTC_EDGE_SEL, 32'hFFFF);
    cfg_write(INTC_ENABLE, 32'hFFFF);
    int_i[7] = 1'b1; step(); int_i[7] = 1'b0; step();
    check("t5_irq", 32'(irq), 32'd1);
    check("t5_id", 32'(irq_id), 32'd7);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("t5_busy", 32'(busy), 32'd1);
    int_i[8] = 1'b1; step(); int_i[8] = 1'b0;
    #3 rst = RstEnable;
    #1;
    check("t5_rst_irq", 32'(irq), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_id", 32'(irq_id), 32'd0);
    cfg_read(INTC_PENDING, d); check("t5_rst_pend", d, 32'h0);
    cfg_read(INTC_STATUS, d);  check("t5_rst_status", d, 32'h0);
    step();
    rst = RstDisable;
    step(3);
    check("t5_post_irq", 32'(irq), 32'd0);
    cfg_read(INTC_STATUS, d); check("t5_post_status", d, 32'h0);

    // Arbitration order with two held level sources
    cfg_write(INTC_ENABLE, 32'h0012);
    int_i = 16'h0012;
`ifdef RV32I_INTC_RR_EN
    exp_q.push_back(1); exp_q.push_back(4); exp_q.push_back(1); exp_q.push_back(4);
`else
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
`endif
    for (int i = 0; i < 4; i++) service($sformatf("t6_%0d", i), 1'b0);
    int_i = '0;
    step(3);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
